reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rv32i_types.sv | 26 ++
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i types: ROB dispatch/commit records and their default sizes.
package rv32i_types;

   localparam int SS_DEF        = 2;
   localparam int ROB_DEPTH_DEF = 8;
   localparam int PR_W_DEF      = 6;

   typedef struct packed {
      logic [4:0]          rd_arch;
      logic [PR_W_DEF-1:0] pd;
      logic [PR_W_DEF-1:0] pd_old;
      logic [31:0]         pc;
      logic [31:0]         inst;
   } rob_entry_t;

   typedef struct packed {
      logic [4:0]          rd_arch;
      logic [PR_W_DEF-1:0] pd;
      logic [PR_W_DEF-1:0] pd_old;
      logic [31:0]         pc;
      logic [31:0]         inst;
      logic [31:0]         rd_data;
      logic [63:0]         order;
   } rob_commit_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: SS-wide dispatch, CDB writeback and commit.
// Optional ROB_RVFI_EN keeps pc/inst per entry and a 64-bit retire-order counter.
module reorder_buffer
   import rv32i_types::*;
#(
   parameter  int SS        = SS_DEF,
   parameter  int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter  int PR_W      = PR_W_DEF,
   localparam int ID_W      = $clog2(ROB_DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [SS-1:0]                dispatch_valid,
   input  rob_entry_t [SS-1:0]          dispatch_entry,
   output logic                         dispatch_ready,
   output logic [SS-1:0][ID_W-1:0]      rob_id_next,
   input  logic [SS-1:0]                cdb_valid,
   input  logic [SS-1:0][ID_W-1:0]      cdb_rob_id,
   input  logic [SS-1:0][31:0]          cdb_rd_data,
   output logic [SS-1:0]                commit_valid,
   output rob_commit_t [SS-1:0]         commit_out,
   output logic                         rob_empty
);

   localparam int CW = ID_W + 1;

   logic [CW-1:0]        r_head, r_tail, r_count;
   logic [ROB_DEPTH-1:0] r_valid, r_done;
   logic [4:0]           r_rd_arch [ROB_DEPTH];
   logic [PR_W-1:0]      r_pd      [ROB_DEPTH];
   logic [PR_W-1:0]      r_pd_old  [ROB_DEPTH];
   logic [31:0]          r_data    [ROB_DEPTH];
`ifdef ROB_RVFI_EN
   logic [31:0]          r_pc      [ROB_DEPTH];
   logic [31:0]          r_inst    [ROB_DEPTH];
   logic [63:0]          r_order;
`else
   logic                 w_unused_rvfi;
`endif

   logic                 w_ready;
   logic [SS-1:0]        w_commit;
   logic [CW-1:0]        w_n_disp, w_n_commit;
   logic [ID_W-1:0]      w_disp_idx [SS];
   logic [ID_W-1:0]      w_cmt_idx  [SS];

   // Only the registered count gates dispatch; same-cycle retirement is not credited.
   assign w_ready = (r_count <= CW'(ROB_DEPTH - SS));

   always_comb begin
      w_n_disp   = '0;
      w_n_commit = '0;
      w_commit   = '0;
      for (int i = 0; i < SS; i++) begin
         w_disp_idx[i] = r_tail[ID_W-1:0] + ID_W'(i);
         w_cmt_idx[i]  = r_head[ID_W-1:0] + ID_W'(i);
      end
      for (int i = 0; i < SS; i++) begin
         w_commit[i] = ((i == 0) ? 1'b1 : w_commit[(i == 0) ? 0 : i-1])
                       && !rst && !flush
                       && r_valid[w_cmt_idx[i]] && r_done[w_cmt_idx[i]];
         w_n_commit  = w_n_commit + CW'(w_commit[i]);
         if (w_ready && dispatch_valid[i])
            w_n_disp = w_n_disp + CW'(1);
      end
   end

   assign dispatch_ready = rst || w_ready;
   assign rob_empty      = rst || (r_count == '0);
   assign commit_valid   = w_commit;

   always_comb begin
      for (int i = 0; i < SS; i++) begin
         rob_id_next[i]        = rst ? ID_W'(i) : w_disp_idx[i];
         commit_out[i]         = '0;
         commit_out[i].rd_arch = r_rd_arch[w_cmt_idx[i]];
         commit_out[i].pd      = r_pd[w_cmt_idx[i]];
         commit_out[i].pd_old  = r_pd_old[w_cmt_idx[i]];
         commit_out[i].rd_data = r_data[w_cmt_idx[i]];
`ifdef ROB_RVFI_EN
         commit_out[i].pc      = r_pc[w_cmt_idx[i]];
         commit_out[i].inst    = r_inst[w_cmt_idx[i]];
         commit_out[i].order   = r_order + 64'(i);
`endif
      end
   end

`ifndef ROB_RVFI_EN
   always_comb begin
      w_unused_rvfi = 1'b0;
      for (int i = 0; i < SS; i++)
         w_unused_rvfi = w_unused_rvfi ^ (^dispatch_entry[i].pc) ^ (^dispatch_entry[i].inst);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_done  <= '0;
`ifdef ROB_RVFI_EN
         r_order <= '0;
`endif
      end else begin
`ifdef ROB_RVFI_EN
         r_order <= r_order + 64'(w_n_commit);
`endif
         if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
         end else begin
            // Ascending lane order: the higher CDB lane wins on an ID collision.
            for (int i = 0; i < SS; i++) begin
               if (cdb_valid[i] && r_valid[cdb_rob_id[i]]) begin
                  r_done[cdb_rob_id[i]] <= 1'b1;
                  r_data[cdb_rob_id[i]] <= cdb_rd_data[i];
               end
            end
            for (int i = 0; i < SS; i++) begin
               if (w_commit[i]) begin
                  r_valid[w_cmt_idx[i]] <= 1'b0;
                  r_done[w_cmt_idx[i]]  <= 1'b0;
               end
            end
            for (int i = 0; i < SS; i++) begin
               if (w_ready && dispatch_valid[i]) begin
                  r_valid[w_disp_idx[i]]   <= 1'b1;
                  r_done[w_disp_idx[i]]    <= 1'b0;
                  r_rd_arch[w_disp_idx[i]] <= dispatch_entry[i].rd_arch;
                  r_pd[w_disp_idx[i]]      <= dispatch_entry[i].pd;
                  r_pd_old[w_disp_idx[i]]  <= dispatch_entry[i].pd_old;
`ifdef ROB_RVFI_EN
                  r_pc[w_disp_idx[i]]      <= dispatch_entry[i].pc;
                  r_inst[w_disp_idx[i]]    <= dispatch_entry[i].inst;
`endif
               end
            end
            r_head  <= r_head + w_n_commit;
            r_tail  <= r_tail + w_n_disp;
            r_count <= r_count + w_n_disp - w_n_commit;
         end
      end
   end

   // Dispatch lanes must fill from lane 0; pointer distance must track the count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_ready)
            assert ((dispatch_valid & (dispatch_valid + SS'(1))) == '0);
         assert (CW'(r_tail - r_head) == r_count);
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed + randomized bench for reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;
   import rv32i_types::*;

   localparam int SS    = 2;
   localparam int DEPTH = 8;
   localparam int ID_W  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst, flush;
   logic [SS-1:0]           dispatch_valid;
   rob_entry_t [SS-1:0]     dispatch_entry;
   logic                    dispatch_ready;
   logic [SS-1:0][ID_W-1:0] rob_id_next;
   logic [SS-1:0]           cdb_valid;
   logic [SS-1:0][ID_W-1:0] cdb_rob_id;
   logic [SS-1:0][31:0]     cdb_rd_data;
   logic [SS-1:0]           commit_valid;
   rob_commit_t [SS-1:0]    commit_out;
   logic                    rob_empty;

   reorder_buffer #(.SS(SS), .ROB_DEPTH(DEPTH), .PR_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
      .dispatch_ready(dispatch_ready), .rob_id_next(rob_id_next),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_data(cdb_rd_data),
      .commit_valid(commit_valid), .commit_out(commit_out), .rob_empty(rob_empty)
   );

   int checks = 0;
   int errors = 0;

   // Model: live IDs in program order, plus per-ID payload and completion state.
   int              q[$];
   int              next_id = 0;
   rob_entry_t      m_ent  [DEPTH];
   logic [31:0]     m_data [DEPTH];
   bit              m_done [DEPTH];
   longint unsigned m_order = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit live(input int id);
      foreach (q[j]) if (q[j] == id) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int exp_k();
      int k = 0;
      if (rst || flush) return 0;
      while (k < SS && k < q.size() && m_done[q[k]]) k++;
      return k;
   endfunction

   task automatic check_outputs();
      int k = exp_k();
      chk("dispatch_ready", dispatch_ready, rst || ((DEPTH - q.size()) >= SS));
      chk("rob_empty", rob_empty, rst || (q.size() == 0));
      for (int i = 0; i < SS; i++) begin
         chk("rob_id_next", rob_id_next[i], rst ? i : (next_id + i) % DEPTH);
         chk("commit_valid", commit_valid[i], i < k);
         if (i < k) begin
            int id = q[i];
            chk("commit_rd_data", commit_out[i].rd_data, m_data[id]);
            chk("commit_pd", commit_out[i].pd, m_ent[id].pd);
            chk("commit_pd_old", commit_out[i].pd_old, m_ent[id].pd_old);
            chk("commit_rd_arch", commit_out[i].rd_arch, m_ent[id].rd_arch);
`ifdef ROB_RVFI_EN
            chk("commit_pc", commit_out[i].pc, m_ent[id].pc);
            chk("commit_inst", commit_out[i].inst, m_ent[id].inst);
            chk("commit_order", commit_out[i].order, m_order + 64'(i));
`else
            chk("commit_pc", commit_out[i].pc, 0);
            chk("commit_inst", commit_out[i].inst, 0);
            chk("commit_order", commit_out[i].order, 0);
`endif
         end
      end
   endtask

   task automatic model_update();
      int k   = exp_k();
      bit rdy = (DEPTH - q.size()) >= SS;
      if (rst) begin
         q.delete(); next_id = 0; m_order = 0;
         foreach (m_done[j]) m_done[j] = 1'b0;
         return;
      end
      if (flush) begin
         q.delete(); next_id = 0;
         foreach (m_done[j]) m_done[j] = 1'b0;
         return;
      end
      for (int i = 0; i < SS; i++)
         if (cdb_valid[i] && live(int'(cdb_rob_id[i]))) begin
            m_done[cdb_rob_id[i]] = 1'b1;
            m_data[cdb_rob_id[i]] = cdb_rd_data[i];
         end
      repeat (k) void'(q.pop_front());
      m_order += longint'(k);
      if (rdy)
         for (int i = 0; i < SS; i++)
            if (dispatch_valid[i]) begin
               q.push_back(next_id);
               m_ent[next_id]  = dispatch_entry[i];
               m_done[next_id] = 1'b0;
               next_id = (next_id + 1) % DEPTH;
            end
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; dispatch_valid = '0; cdb_valid = '0;
   endtask

   task automatic disp(input int n);
      dispatch_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
      for (int i = 0; i < SS; i++) begin
         dispatch_entry[i].rd_arch = 5'($urandom);
         dispatch_entry[i].pd      = 6'($urandom);
         dispatch_entry[i].pd_old  = 6'($urandom);
         dispatch_entry[i].pc      = $urandom;
         dispatch_entry[i].inst    = $urandom;
      end
   endtask

   task automatic cdb(input int lane, input int id, input logic [31:0] d);
      cdb_valid[lane]   = 1'b1;
      cdb_rob_id[lane]  = ID_W'(id);
      cdb_rd_data[lane] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1; idle();
      step(); step();
      rst = 1'b0;
   endtask

   task automatic complete_live();
      for (int c = 0; c < 2 * DEPTH; c++) begin
         int lane = 0;
         idle();
         foreach (q[j]) if (!m_done[q[j]] && lane < SS) begin
            cdb(lane, q[j], $urandom); lane++;
         end
         if (lane == 0) break;
         step();
      end
      idle();
   endtask

   task automatic drain();
      idle();
      for (int c = 0; c < 2 * DEPTH && q.size() != 0; c++) step();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      dispatch_valid = '0; dispatch_entry = '0;
      cdb_valid = '0; cdb_rob_id = '0; cdb_rd_data = '0;

      // Reset state, first dispatch pair with pd 10/11
      do_reset();
      disp(2);
      dispatch_entry[0].pd = 6'd10; dispatch_entry[1].pd = 6'd11;
      #1;
      chk("t1_id_next0", rob_id_next[0], 0);
      chk("t1_id_next1", rob_id_next[1], 1);
      step(); idle(); #1;
      chk("t1_id_next0_after", rob_id_next[0], 2);
      chk("t1_id_next1_after", rob_id_next[1], 3);
      chk("t1_not_empty", rob_empty, 0);
      chk("t1_no_commit", commit_valid, 0);

      // Out-of-order completion, in-order dual retirement
      cdb(0, 1, 32'hBEEF); step();
      idle(); cdb(0, 0, 32'h1234); #1;
      chk("t2_no_commit_yet", commit_valid, 0);
      step(); idle(); #1;
      chk("t2_dual_commit", commit_valid, 2'b11);
      chk("t2_rd_data0", commit_out[0].rd_data, 32'h1234);
      chk("t2_rd_data1", commit_out[1].rd_data, 32'hBEEF);
      chk("t2_pd0", commit_out[0].pd, 10);
      step();

      // Full buffer: ready low at 8, held dispatch, recovery after commit; ready low at 7
      do_reset();
      for (int c = 0; c < 4; c++) begin disp(2); step(); end
      idle(); #1;
      chk("t3_ready_full", dispatch_ready, 0);
      disp(2); step();
      idle(); #1;
      chk("t3_ready_held", dispatch_ready, 0);
      cdb(0, 0, 32'h11); cdb(1, 1, 32'h22); step();
      idle(); #1;
      chk("t3_commit2", commit_valid, 2'b11);
      chk("t3_ready_no_credit", dispatch_ready, 0);
      step(); #1;
      chk("t3_ready_back", dispatch_ready, 1);
      disp(1); step(); idle(); #1;
      chk("t3_ready_count7", dispatch_ready, 0);
      complete_live(); drain();

      // Wrap-around of IDs and retirement order
      do_reset();
      for (int c = 0; c < 3; c++) begin disp(2); step(); end
      complete_live(); drain(); #1;
      chk("t4_id_next6", rob_id_next[0], 6);
      chk("t4_id_next7", rob_id_next[1], 7);
      disp(2); step(); idle(); #1;
      chk("t4_wrap_id0", rob_id_next[0], 0);
      chk("t4_wrap_id1", rob_id_next[1], 1);
      disp(2); step();
      complete_live(); drain();

      // Flush with five entries and same-cycle dispatch/CDB
      do_reset();
      disp(2); step(); cdb(0, 0, 32'h5); cdb(1, 1, 32'h6); step(); idle(); step();
      disp(2); step(); disp(2); step(); disp(1); step();
      idle(); cdb(0, 2, 32'hAA); step();
      flush = 1'b1; disp(2); cdb(0, 3, 32'h77); #1;
      chk("t5_commit_blocked", commit_valid, 0);
      step(); idle(); #1;
      chk("t5_empty", rob_empty, 1);
      chk("t5_id_next0", rob_id_next[0], 0);
      chk("t5_id_next1", rob_id_next[1], 1);
      disp(2); step(); complete_live(); drain();

      // CDB to an unallocated ID, then a same-ID CDB collision
      do_reset();
      disp(2); step(); disp(1); step();
      idle(); cdb(0, 5, 32'hDEAD); step();
      idle(); #1;
      chk("t6_no_commit", commit_valid, 0);
      chk("t6_not_empty", rob_empty, 0);
      chk("t6_id_next", rob_id_next[0], 3);
      cdb(0, 0, 32'hAAAA); cdb(1, 0, 32'hBBBB); step();
      idle(); #1;
      chk("t6_collision_valid", commit_valid[0], 1);
      chk("t6_collision_data", commit_out[0].rd_data, 32'hBBBB);
      step();
      disp(2); step(); disp(1); step();
      complete_live(); drain();

      // Randomized traffic, with one mid-stream reset
      for (int c = 0; c < 600; c++) begin
         idle();
         rst = (c == 300);
         flush = ($urandom_range(0, 59) == 0);
         disp($urandom_range(0, 2));
         for (int l = 0; l < SS; l++) begin
            if (q.size() != 0 && $urandom_range(0, 2) != 0)
               cdb(l, q[$urandom_range(0, q.size() - 1)], $urandom);
            else if ($urandom_range(0, 9) == 0)
               cdb(l, $urandom_range(0, DEPTH - 1), $urandom);
         end
         step();
      end
      rst = 1'b0;
      idle(); complete_live(); drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
